spi_arb: RTL and testbench

Arbiter and sequencer sharing one `SPI_mnrch` between two SPI clients: requester 0 is the inertial interface and requester 1 is the IR/A2D interface. Each client hands the arbiter a 16-bit command with a one-cycle request pulse. The arbiter buffers one command per client, serves the clients round-robin, and routes the monarch's `SS_n` to the owning slave. It returns read data with a per-client done pulse and enforces an idle gap between back-to-back transactions.

---
 rtl/spi_arb_if.sv | 37 +++
 rtl/spi_arb.sv | 155 +++++++++++++++
 tb/tb_spi_arb.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arb_if.sv
// ----------------------------------------------------------------------------
// spi_arb_if
// Bundle of every non-clock/reset signal of spi_arb.
//   client side : req0/req1, cmd0/cmd1 (in), done0/done1, rd_data, ovf0/ovf1,
//                 busy (out), clr_ovf (in)
//   monarch side: spi_wrt, spi_cmd (out), spi_done, spi_rd, mn_SS_n (in)
//   slave select: SS0_n, SS1_n (out)
// Modport 'slave' is the arbiter's view. Modport 'master' is the view of
// whatever drives it: the clients plus the SPI monarch.
// ----------------------------------------------------------------------------
interface spi_arb_if;
   logic        req0, req1;
   logic [15:0] cmd0, cmd1;
   logic        done0, done1;
   logic [15:0] rd_data;
   logic        ovf0, ovf1;
   logic        clr_ovf;
   logic        busy;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        spi_done;
   logic [15:0] spi_rd;
   logic        mn_SS_n;
   logic        SS0_n, SS1_n;

   modport slave (
      input  req0, req1, cmd0, cmd1, clr_ovf, spi_done, spi_rd, mn_SS_n,
      output done0, done1, rd_data, ovf0, ovf1, busy, spi_wrt, spi_cmd,
             SS0_n, SS1_n
   );

   modport master (
      output req0, req1, cmd0, cmd1, clr_ovf, spi_done, spi_rd, mn_SS_n,
      input  done0, done1, rd_data, ovf0, ovf1, busy, spi_wrt, spi_cmd,
             SS0_n, SS1_n
   );
endinterface

// File: rtl/spi_arb.sv
// ----------------------------------------------------------------------------
// spi_arb
// Shares one SPI monarch between two clients (0: inertial, 1: IR/A2D).
// Each client has a one-deep command buffer. Pending clients are served
// round-robin. The monarch's slave select is steered to the current owner,
// and an idle gap of GAP_CYC clocks is inserted after every transaction.
// Ports:
//   clk  : system clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : spi_arb_if.slave (client handshakes, monarch controls, SS routing)
// ----------------------------------------------------------------------------
module spi_arb #(
   parameter int GAP_CYC = 4
) (
   input  logic      clk,
   input  logic      rst,
   spi_arb_if.slave  bus
);

   localparam int            GW     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GW-1:0] GAP_LD = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_XFER,
      S_DONE,
      S_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         pend_q, pend_d;
   logic [1:0][15:0]   buf_q, buf_d;
   logic [1:0]         ovf_q, ovf_d;
   logic               owner_q, owner_d;
   logic               last_q, last_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic [15:0]        rd_q, rd_d;
   logic [15:0]        cmd_q, cmd_d;

   logic [1:0]         req_v;
   logic [1:0][15:0]   cmd_v;
   logic [1:0]         done_v;

   assign req_v = {bus.req1, bus.req0};
   assign cmd_v = {bus.cmd1, bus.cmd0};

   // done for a client is simply "in DONE and that client owns the bus"
   assign done_v[0] = (state_q == S_DONE) && (owner_q == 1'b0);
   assign done_v[1] = (state_q == S_DONE) && (owner_q == 1'b1);

   // -------------------------------------------------------------------------
   // Command buffers and overflow flags
   // -------------------------------------------------------------------------
   always_comb begin
      pend_d = pend_q;
      buf_d  = buf_q;
      ovf_d  = ovf_q;
      for (int i = 0; i < 2; i++) begin
         if (done_v[i]) pend_d[i] = 1'b0;
         if (bus.clr_ovf) ovf_d[i] = 1'b0;
         if (req_v[i]) begin
            // a request landing on its own done slot refills the buffer
            // the buffer is being emptied in that same cycle, so no overflow
            if (pend_q[i] && !done_v[i]) begin
               ovf_d[i] = 1'b1;
            end else begin
               pend_d[i] = 1'b1;
               buf_d[i]  = cmd_v[i];
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Sequencer
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      gap_d   = gap_q;
      rd_d    = rd_q;
      cmd_d   = cmd_q;
      case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               // both pending: the client that did not finish last goes next
               if (&pend_q) owner_d = ~last_q;
               else         owner_d = pend_q[1];
               cmd_d   = buf_q[owner_d];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_XFER;
         S_XFER: begin
            if (bus.spi_done) begin
               rd_d    = bus.spi_rd;
               last_d  = owner_q;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            gap_d   = GAP_LD;
            state_d = (GAP_CYC > 0) ? S_GAP : S_IDLE;
         end
         S_GAP: begin
            if (gap_q == '0) state_d = S_IDLE;
            else             gap_d   = gap_q - GW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         buf_q   <= '0;
         ovf_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         gap_q   <= '0;
         rd_q    <= '0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         buf_q   <= buf_d;
         ovf_q   <= ovf_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         gap_q   <= gap_d;
         rd_q    <= rd_d;
         cmd_q   <= cmd_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.done0   = done_v[0];
   assign bus.done1   = done_v[1];
   assign bus.rd_data = rd_q;
   assign bus.ovf0    = ovf_q[0];
   assign bus.ovf1    = ovf_q[1];
   assign bus.busy    = (state_q != S_IDLE);
   assign bus.spi_wrt = (state_q == S_ISSUE);
   assign bus.spi_cmd = cmd_q;

   // the non-owner's select is forced high; owner_q holds after completion
   assign bus.SS0_n = bus.mn_SS_n | (owner_q != 1'b0);
   assign bus.SS1_n = bus.mn_SS_n | (owner_q != 1'b1);

endmodule

// File: tb/tb_spi_arb.sv
// ----------------------------------------------------------------------------
// tb_spi_arb
// Two arbiters (GAP_CYC=4 and GAP_CYC=0) share one set of stimulus; 'sel'
// picks the one being checked. A cycle-level reference model tracks buffer
// occupancy, the round-robin pointer and cycle numbers of the next allowed
// issue, and every DUT output is compared against it each clock.
// ----------------------------------------------------------------------------
module tb_spi_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req0, req1, clr_ovf, spi_done, mn_SS_n;
   logic [15:0] cmd0, cmd1, spi_rd;
   logic        sel;
   int          gap_g;

   spi_arb_if ifa();
   spi_arb_if ifb();

   assign ifa.req0 = req0;  assign ifb.req0 = req0;
   assign ifa.req1 = req1;  assign ifb.req1 = req1;
   assign ifa.cmd0 = cmd0;  assign ifb.cmd0 = cmd0;
   assign ifa.cmd1 = cmd1;  assign ifb.cmd1 = cmd1;
   assign ifa.clr_ovf  = clr_ovf;  assign ifb.clr_ovf  = clr_ovf;
   assign ifa.spi_done = spi_done; assign ifb.spi_done = spi_done;
   assign ifa.spi_rd   = spi_rd;   assign ifb.spi_rd   = spi_rd;
   assign ifa.mn_SS_n  = mn_SS_n;  assign ifb.mn_SS_n  = mn_SS_n;

   spi_arb #(.GAP_CYC(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   spi_arb #(.GAP_CYC(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   // observed outputs of the selected DUT
   logic        o_wrt, o_busy, o_d0, o_d1, o_ovf0, o_ovf1, o_ss0, o_ss1;
   logic [15:0] o_rd, o_cmd;

   // reference model
   int          cyc, idle_from, done_c, wrt_c;
   bit          txn, got;
   logic        mown, mlast;
   logic [1:0]  mp, movf;
   logic [15:0] mbuf[2];
   int          vis[2];
   logic [15:0] mrd, mcmd;

   // monarch / stimulus helpers
   int          mon_cnt;
   bit          auto0, auto1, stray_now;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [15:0] got_v, input logic [15:0] exp_v);
      n_cmp++;
      if (got_v !== exp_v) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got_v, exp_v);
      end
   endtask

   task automatic sample();
      o_wrt  = sel ? ifb.spi_wrt : ifa.spi_wrt;
      o_busy = sel ? ifb.busy    : ifa.busy;
      o_d0   = sel ? ifb.done0   : ifa.done0;
      o_d1   = sel ? ifb.done1   : ifa.done1;
      o_ovf0 = sel ? ifb.ovf0    : ifa.ovf0;
      o_ovf1 = sel ? ifb.ovf1    : ifa.ovf1;
      o_ss0  = sel ? ifb.SS0_n   : ifa.SS0_n;
      o_ss1  = sel ? ifb.SS1_n   : ifa.SS1_n;
      o_rd   = sel ? ifb.rd_data : ifa.rd_data;
      o_cmd  = sel ? ifb.spi_cmd : ifa.spi_cmd;
   endtask

   task automatic do_reset();
      @(negedge clk); cyc++;
      rst = 1'b1;
      req0 = 0; req1 = 0; cmd0 = '0; cmd1 = '0; clr_ovf = 0;
      spi_done = 0; spi_rd = '0; mn_SS_n = 1'b1;
      mon_cnt = 0;
      @(negedge clk); cyc++;
      sample();
      chk("rst_busy", o_busy, 0);
      chk("rst_wrt",  o_wrt, 0);
      chk("rst_done0", o_d0, 0);
      chk("rst_done1", o_d1, 0);
      chk("rst_rd",   o_rd, 0);
      chk("rst_cmd",  o_cmd, 0);
      chk("rst_ovf0", o_ovf0, 0);
      chk("rst_ovf1", o_ovf1, 0);
      chk("rst_SS0",  o_ss0, mn_SS_n);
      chk("rst_SS1",  o_ss1, mn_SS_n);
      rst = 1'b0;
      mp = '0; movf = '0; mbuf[0] = '0; mbuf[1] = '0;
      txn = 0; got = 0; done_c = -100; wrt_c = -100; idle_from = cyc;
      mown = 1'b0; mlast = 1'b1; mrd = '0; mcmd = '0;
   endtask

   // one clock: check outputs of this cycle, then drive inputs for it
   task automatic cycle(input logic r0, input logic [15:0] c0,
                        input logic r1, input logic [15:0] c1, input logic clr);
      logic        ew, el0, el1, sd, ssn;
      logic [15:0] srd;
      @(negedge clk); cyc++;

      // an issue happens one clock after an idle cycle that saw a pending client
      ew = 1'b0;
      if (!txn && (cyc - 1 >= idle_from)) begin
         el0 = mp[0] && (vis[0] <= cyc - 1);
         el1 = mp[1] && (vis[1] <= cyc - 1);
         if (el0 || el1) begin
            ew    = 1'b1;
            mown  = (el0 && el1) ? ~mlast : el1;
            txn   = 1;
            got   = 0;
            wrt_c = cyc;
            mcmd  = mbuf[mown];
         end
      end

      sample();
      chk("spi_wrt", o_wrt, ew);
      chk("busy",    o_busy, txn || (cyc < idle_from));
      chk("done0",   o_d0, (cyc == done_c) && (mown == 1'b0));
      chk("done1",   o_d1, (cyc == done_c) && (mown == 1'b1));
      chk("rd_data", o_rd, mrd);
      chk("spi_cmd", o_cmd, mcmd);
      chk("ovf0",    o_ovf0, movf[0]);
      chk("ovf1",    o_ovf1, movf[1]);
      chk("SS0_n",   o_ss0, mn_SS_n | (mown != 1'b0));
      chk("SS1_n",   o_ss1, mn_SS_n | (mown != 1'b1));

      if (auto0 && o_d0) r0 = 1'b1;
      if (auto1 && o_d1) r1 = 1'b1;

      // monarch: finishes 1..5 clocks after the start pulse, sometimes strays
      sd  = 1'b0;
      srd = 16'($urandom);
      if (mon_cnt > 0) begin
         mon_cnt--;
         if (mon_cnt == 0) sd = 1'b1;
      end else if (!o_wrt && ($urandom_range(0, 15) == 0)) begin
         sd = 1'b1;
      end
      if (stray_now) begin sd = 1'b1; stray_now = 0; end
      if (o_wrt) mon_cnt = $urandom_range(1, 5);
      ssn = (mon_cnt == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);

      req0 = r0; cmd0 = c0; req1 = r1; cmd1 = c1; clr_ovf = clr;
      spi_done = sd; spi_rd = srd; mn_SS_n = ssn;

      // model update for what this cycle's inputs cause
      if (cyc == done_c) begin mp[mown] = 1'b0; txn = 0; end
      if (txn && !got && (cyc > wrt_c) && sd) begin
         got       = 1;
         done_c    = cyc + 1;
         idle_from = cyc + 2 + gap_g;
         mrd       = srd;
         mlast     = mown;
      end
      if (clr) movf = '0;
      if (r0) begin
         if (mp[0]) movf[0] = 1'b1;
         else begin mp[0] = 1'b1; mbuf[0] = c0; vis[0] = cyc + 1; end
      end
      if (r1) begin
         if (mp[1]) movf[1] = 1'b1;
         else begin mp[1] = 1'b1; mbuf[1] = c1; vis[1] = cyc + 1; end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(0, 16'($urandom), 0, 16'($urandom), 0);
   endtask

   task automatic rand_run(input int n);
      for (int k = 0; k < n; k++)
         cycle($urandom_range(0, 5) == 0, 16'($urandom),
               $urandom_range(0, 5) == 0, 16'($urandom),
               $urandom_range(0, 24) == 0);
   endtask

   initial begin
      bit reached;
      cyc = 0; sel = 1'b0; gap_g = 4;
      auto0 = 0; auto1 = 0; stray_now = 0; mon_cnt = 0;
      req0 = 0; req1 = 0; cmd0 = '0; cmd1 = '0; clr_ovf = 0;
      spi_done = 0; spi_rd = '0; mn_SS_n = 1'b1;

      // ---------------- GAP_CYC = 4 ----------------
      do_reset();
      cycle(1, 16'hA600, 1, 16'h0C00, 0);     // simultaneous: client 0 first
      idle(30);
      cycle(1, 16'hA600, 0, 16'h0000, 0);     // single request
      idle(15);

      auto0 = 1; auto1 = 1;                   // fairness: both keep re-requesting
      cycle(1, 16'h1111, 1, 16'h2222, 0);
      for (int k = 0; k < 80; k++) cycle(0, 16'($urandom), 0, 16'($urandom), 0);
      auto0 = 0; auto1 = 0;
      idle(40);

      cycle(0, 16'h0, 1, 16'hABCD, 0);        // overflow on client 1
      cycle(0, 16'h0, 1, 16'h1234, 0);
      idle(20);
      cycle(0, 16'h0, 0, 16'h0, 1);           // clear
      idle(5);

      rand_run(500);

      // reset while transferring with client 1 pending
      reached = 0;
      for (int k = 0; k < 300 && !reached; k++) begin
         cycle($urandom_range(0, 3) == 0, 16'($urandom), 1, 16'($urandom), 0);
         if (txn && !got && (cyc >= wrt_c) && mp[1]) reached = 1;
      end
      chk("xfer_reach", reached, 1);
      do_reset();
      stray_now = 1;
      idle(20);
      rand_run(200);

      // ---------------- GAP_CYC = 0 ----------------
      sel = 1'b1; gap_g = 0;
      do_reset();
      cycle(1, 16'h5A5A, 1, 16'hC3C3, 0);     // back-to-back
      idle(20);
      rand_run(400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
